// File: rtl/control_pkg.sv
// control_pkg
//   Shared constants for the RV32I main control decoder: the nine base
//   opcodes that the core executes, the bit position of every strobe on
//   the 11-bit control bus, and the all-zero NOP bus value.
//   Configuration macro: none used here (see control_decoder for
//   CONTROL_REG_OUT_EN).
package control_pkg;

  localparam int CTL_W = 11;

  // Base RV32I opcodes, instruction[6:0]
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Strobe positions on the control bus, MSB first
  localparam int CTL_REG_WRITE  = 10;
  localparam int CTL_MEM_WR     = 9;
  localparam int CTL_MEM_RD     = 8;
  localparam int CTL_BRANCH     = 7;
  localparam int CTL_MEM_TO_REG = 6;
  localparam int CTL_JAL        = 5;
  localparam int CTL_IMM_TO_REG = 4;
  localparam int CTL_ALU_SRC_A  = 3;
  localparam int CTL_ALU_SRC_B  = 2;
  localparam int CTL_PC_TO_REG  = 1;
  localparam int CTL_CMP_BRANCH = 0;

  // No write, no memory access, no control transfer
  localparam logic [CTL_W-1:0] CTL_NOP = 11'b0;

endpackage

// File: rtl/control_decode_rom.sv
// control_decode_rom
//   Purely combinational opcode -> control bus lookup.
//   Ports:
//     opcode_w_i   in   7  instruction[6:0]
//     ctl_bus_w_o  out 11  {reg_write, mem_wr, mem_rd, branch, mem_to_reg,
//                           jal, imm_to_reg, alu_src_a, alu_src_b,
//                           pc_to_reg, cmp_branch}
//     illegal_w_o  out  1  opcode is not one of the nine supported ones
//   Configuration macro: none.
module control_decode_rom
  import control_pkg::*;
(
  input  logic [6:0]       opcode_w_i,
  output logic [CTL_W-1:0] ctl_bus_w_o,
  output logic             illegal_w_o
);

  // Exact match on all seven bits. A plain case uses identity matching, so
  // an opcode carrying X/Z bits in simulation falls through to the default
  // and is reported as illegal with a NOP bus.
  always_comb begin
    ctl_bus_w_o = CTL_NOP;
    illegal_w_o = 1'b0;
    case (opcode_w_i)
      OPC_JAL:    ctl_bus_w_o = 11'b100_1010_1110;
      OPC_JALR:   ctl_bus_w_o = 11'b100_1010_1110;
      OPC_LUI:    ctl_bus_w_o = 11'b100_0001_0000;
      OPC_AUIPC:  ctl_bus_w_o = 11'b100_0000_1100;
      OPC_BRANCH: ctl_bus_w_o = 11'b000_1000_1101;
      OPC_STORE:  ctl_bus_w_o = 11'b010_0000_0000;
      OPC_LOAD:   ctl_bus_w_o = 11'b101_0100_0100;
      OPC_OP_IMM: ctl_bus_w_o = 11'b100_0000_0100;
      OPC_OP:     ctl_bus_w_o = 11'b100_0000_0000;
      default: begin
        ctl_bus_w_o = CTL_NOP;
        illegal_w_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_decoder.sv
// control_decoder
//   Main control decoder of the RV32I single-issue core. Turns the opcode
//   into the datapath control strobes and flags illegal opcodes, keeping a
//   sticky copy of the illegal flag for the trap/debug logic.
//   Ports:
//     clk_w_i               in  1  core clock, rising edge
//     rst_w_i_h             in  1  asynchronous active-high reset
//     opcode_w_i            in  7  instruction[6:0]
//     reg_write_w_o_h       out 1  write rd
//     mem_wr_w_o_h          out 1  data memory write
//     mem_rd_w_o_h          out 1  data memory read
//     branch_w_o_h          out 1  control transfer (B, JAL, JALR)
//     mem_to_reg_w_o_h      out 1  writeback = load data
//     jal_w_o_h             out 1  unconditional jump
//     imm_to_reg_w_o_h      out 1  writeback = U-immediate
//     alu_src_a_w_o         out 1  ALU A: 1=PC, 0=rs1
//     alu_src_b_w_o         out 1  ALU B: 1=imm, 0=rs2
//     pc_to_reg_w_o         out 1  writeback = PC+4
//     cmp_branch_w_o_h      out 1  conditional branch
//     illegal_w_o_h         out 1  unsupported opcode
//     illegal_sticky_w_o_h  out 1  illegal seen since reset
//   Configuration macro: CONTROL_REG_OUT_EN registers the strobes and the
//   illegal flag (one cycle latency, reset to NOP). Undefined: combinational.
module control_decoder
  import control_pkg::*;
(
  input  logic       clk_w_i,
  input  logic       rst_w_i_h,
  input  logic [6:0] opcode_w_i,
  output logic       reg_write_w_o_h,
  output logic       mem_wr_w_o_h,
  output logic       mem_rd_w_o_h,
  output logic       branch_w_o_h,
  output logic       mem_to_reg_w_o_h,
  output logic       jal_w_o_h,
  output logic       imm_to_reg_w_o_h,
  output logic       alu_src_a_w_o,
  output logic       alu_src_b_w_o,
  output logic       pc_to_reg_w_o,
  output logic       cmp_branch_w_o_h,
  output logic       illegal_w_o_h,
  output logic       illegal_sticky_w_o_h
);

  logic [CTL_W-1:0] rom_bus;
  logic             rom_illegal;
  logic [CTL_W-1:0] out_bus;
  logic             out_illegal;

  control_decode_rom u_rom (
    .opcode_w_i  (opcode_w_i),
    .ctl_bus_w_o (rom_bus),
    .illegal_w_o (rom_illegal)
  );

`ifdef CONTROL_REG_OUT_EN
  // Output stage: reset parks the datapath on a NOP so nothing is written
  // or transferred while the core comes out of reset.
  always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
    if (rst_w_i_h) begin
      out_bus     <= CTL_NOP;
      out_illegal <= 1'b0;
    end else begin
      out_bus     <= rom_bus;
      out_illegal <= rom_illegal;
    end
  end
`else
  assign out_bus     = rom_bus;
  assign out_illegal = rom_illegal;
`endif

  // Sticky flag follows whatever illegal flag the core actually sees, so in
  // the registered build it lags the opcode by one extra cycle.
  always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
    if (rst_w_i_h) begin
      illegal_sticky_w_o_h <= 1'b0;
    end else if (out_illegal) begin
      illegal_sticky_w_o_h <= 1'b1;
    end
  end

  assign reg_write_w_o_h  = out_bus[CTL_REG_WRITE];
  assign mem_wr_w_o_h     = out_bus[CTL_MEM_WR];
  assign mem_rd_w_o_h     = out_bus[CTL_MEM_RD];
  assign branch_w_o_h     = out_bus[CTL_BRANCH];
  assign mem_to_reg_w_o_h = out_bus[CTL_MEM_TO_REG];
  assign jal_w_o_h        = out_bus[CTL_JAL];
  assign imm_to_reg_w_o_h = out_bus[CTL_IMM_TO_REG];
  assign alu_src_a_w_o    = out_bus[CTL_ALU_SRC_A];
  assign alu_src_b_w_o    = out_bus[CTL_ALU_SRC_B];
  assign pc_to_reg_w_o    = out_bus[CTL_PC_TO_REG];
  assign cmp_branch_w_o_h = out_bus[CTL_CMP_BRANCH];
  assign illegal_w_o_h    = out_illegal;

endmodule

// File: tb/tb_control_decoder.sv
// tb_control_decoder
//   Self-checking bench for control_decoder. Expected control words come
//   from the decode table written out independently below; a queue holds
//   them between driving an opcode and seeing its result, which absorbs
//   the extra cycle of the CONTROL_REG_OUT_EN build.
module tb_control_decoder;

`ifdef CONTROL_REG_OUT_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [6:0]  opc;
    logic [10:0] bus;
    logic        ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic reg_write, mem_wr, mem_rd, branch, mem_to_reg, jal, imm_to_reg;
  logic alu_src_a, alu_src_b, pc_to_reg, cmp_branch, illegal, sticky;
  logic [10:0] bus;

  int pass_count = 0;
  int check_count = 0;
  exp_t sb[$];

  assign bus = {reg_write, mem_wr, mem_rd, branch, mem_to_reg, jal,
                imm_to_reg, alu_src_a, alu_src_b, pc_to_reg, cmp_branch};

  control_decoder dut (
    .clk_w_i              (clk),
    .rst_w_i_h            (rst),
    .opcode_w_i           (opcode),
    .reg_write_w_o_h      (reg_write),
    .mem_wr_w_o_h         (mem_wr),
    .mem_rd_w_o_h         (mem_rd),
    .branch_w_o_h         (branch),
    .mem_to_reg_w_o_h     (mem_to_reg),
    .jal_w_o_h            (jal),
    .imm_to_reg_w_o_h     (imm_to_reg),
    .alu_src_a_w_o        (alu_src_a),
    .alu_src_b_w_o        (alu_src_b),
    .pc_to_reg_w_o        (pc_to_reg),
    .cmp_branch_w_o_h     (cmp_branch),
    .illegal_w_o_h        (illegal),
    .illegal_sticky_w_o_h (sticky)
  );

  always #5 clk = ~clk;

  // Reference decode table
  function automatic exp_t model(input logic [6:0] opc);
    exp_t e;
    e.opc = opc;
    e.ill = 1'b0;
    case (opc)
      7'b1101111: e.bus = 11'b10010101110;
      7'b1100111: e.bus = 11'b10010101110;
      7'b0110111: e.bus = 11'b10000010000;
      7'b0010111: e.bus = 11'b10000001100;
      7'b1100011: e.bus = 11'b00010001101;
      7'b0100011: e.bus = 11'b01000000000;
      7'b0000011: e.bus = 11'b10101000100;
      7'b0010011: e.bus = 11'b10000000100;
      7'b0110011: e.bus = 11'b10000000000;
      default: begin
        e.bus = 11'b0;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic test_reset();
    logic [10:0] exp_bus;
    logic        exp_ill;
    rst = 1'b1;
    opcode = 7'b0110011;
    #3;
    exp_bus = (LAT == 0) ? 11'b10000000000 : 11'b0;
    exp_ill = 1'b0;
    check_count++;
    if (bus !== exp_bus)
      $display("[TB] FAIL reset_bus actual=%b required=%b", bus, exp_bus);
    else pass_count++;
    check_count++;
    if (illegal !== exp_ill)
      $display("[TB] FAIL reset_illegal actual=%b required=%b", illegal, exp_ill);
    else pass_count++;
    check_count++;
    if (sticky !== 1'b0)
      $display("[TB] FAIL reset_sticky actual=%b required=0", sticky);
    else pass_count++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_illegal_sticky();
    exp_t e;
    @(posedge clk);
    #1 opcode = 7'b0000000;
    sb.push_back(model(7'b0000000));
    @(negedge clk);
    check_count++;
    if (sticky !== 1'b0)
      $display("[TB] FAIL sticky_before_edge actual=%b required=0", sticky);
    else pass_count++;
    for (int i = 0; i < LAT; i++) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check_count++;
    if (bus !== e.bus || illegal !== e.ill)
      $display("[TB] FAIL illegal_zero actual=%b/%b required=%b/%b",
               bus, illegal, e.bus, e.ill);
    else pass_count++;
    @(posedge clk);
    @(negedge clk);
    check_count++;
    if (sticky !== 1'b1)
      $display("[TB] FAIL sticky_set actual=%b required=1", sticky);
    else pass_count++;
  endtask

  task automatic test_decode_table();
    logic [6:0] opcs[11];
    exp_t e;
    opcs = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011,
             7'b0100011, 7'b0000011, 7'b0010011, 7'b0110011, 7'b1111111,
             7'b0110001};
    foreach (opcs[i]) begin
      @(posedge clk);
      #1 opcode = opcs[i];
      sb.push_back(model(opcs[i]));
      @(negedge clk);
      if (sb.size() > LAT) begin
        e = sb.pop_front();
        check_count++;
        if (bus !== e.bus)
          $display("[TB] FAIL table_bus opc=%b actual=%b required=%b", e.opc, bus, e.bus);
        else pass_count++;
        check_count++;
        if (illegal !== e.ill)
          $display("[TB] FAIL table_illegal opc=%b actual=%b required=%b", e.opc, illegal, e.ill);
        else pass_count++;
      end
    end
    while (sb.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check_count++;
      if (bus !== e.bus)
        $display("[TB] FAIL table_bus opc=%b actual=%b required=%b", e.opc, bus, e.bus);
      else pass_count++;
      check_count++;
      if (illegal !== e.ill)
        $display("[TB] FAIL table_illegal opc=%b actual=%b required=%b", e.opc, illegal, e.ill);
      else pass_count++;
    end
  endtask

  task automatic test_sticky_async_clear();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_count++;
    if (sticky !== 1'b0)
      $display("[TB] FAIL sticky_async_clear actual=%b required=0", sticky);
    else pass_count++;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [6:0] legal[9];
    logic [6:0] opc;
    exp_t e;
    legal = '{7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1100011,
              7'b0100011, 7'b0000011, 7'b0010011, 7'b0110011};
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) opc = 7'($urandom_range(0, 127));
      else opc = legal[$urandom_range(0, 8)];
      @(posedge clk);
      #1 opcode = opc;
      sb.push_back(model(opc));
      @(negedge clk);
      if (sb.size() > LAT) begin
        e = sb.pop_front();
        check_count++;
        if (bus !== e.bus || illegal !== e.ill)
          $display("[TB] FAIL b2b opc=%b actual=%b/%b required=%b/%b",
                   e.opc, bus, illegal, e.bus, e.ill);
        else pass_count++;
      end
    end
    while (sb.size() > 0) begin
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      check_count++;
      if (bus !== e.bus || illegal !== e.ill)
        $display("[TB] FAIL b2b opc=%b actual=%b/%b required=%b/%b",
                 e.opc, bus, illegal, e.bus, e.ill);
      else pass_count++;
    end
  endtask

  initial begin
    test_reset();
    test_illegal_sticky();
    test_decode_table();
    test_sticky_async_clear();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
